bsg_fsb_node_domain_ls_gate: RTL and testbench

Node-domain end of the FSB level-shift boundary, the counterpart of the FSB-domain level shifter. It owns the enable sequencing for the shift cells: it raises `en_ls_o`, waits for the shifted nets to settle, then opens the handshakes. On disable it drains any in-flight output packet before isolating again. It also buffers FSB-to-node traffic in a 2-entry FIFO, so the ready returned across the boundary is register-driven.

---
 rtl/bsg_fsb_node_domain_ls_gate.sv | 172 +++++++++++++++++
 tb/tb_bsg_fsb_node_domain_ls_gate.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fsb_node_domain_ls_gate.sv
// Node-domain side of the FSB level-shift boundary: sequences the shift-cell
// enable, drains an in-flight node-to-FSB packet on disable, and buffers FSB-to-node traffic.
module bsg_fsb_node_domain_ls_gate #(
  parameter int unsigned ring_width_p    = 80,
  parameter int unsigned settle_cycles_p = 4,
  parameter int unsigned drain_timeout_p = 255
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_req_i,
  output logic                    en_ls_o,
  output logic                    active_o,
  output logic                    drain_timeout_o,
  input  logic                    ls_v_i,
  input  logic [ring_width_p-1:0] ls_data_i,
  output logic                    ls_ready_o,
  output logic                    core_v_o,
  output logic [ring_width_p-1:0] core_data_o,
  input  logic                    core_yumi_i,
  input  logic                    core_out_v_i,
  input  logic [ring_width_p-1:0] core_out_data_i,
  output logic                    core_out_yumi_o,
  output logic                    ls_v_o,
  output logic [ring_width_p-1:0] ls_data_o,
  input  logic                    ls_yumi_i
);

  localparam int unsigned CW = (settle_cycles_p > 1) ? $clog2(settle_cycles_p) : 1;
  localparam int unsigned DW = (drain_timeout_p > 0) ? $clog2(drain_timeout_p + 1) : 1;

  typedef enum logic [1:0] {S_ISOLATED, S_ARMING, S_ACTIVE, S_DRAINING} state_e;

  state_e                  r_state, w_next_state;
  logic                    r_sync1, r_sync2;
  logic [CW-1:0]           r_cnt, w_cnt_next;
  logic [DW-1:0]           r_dcnt, w_dcnt_next;
  logic                    w_timeout;
  logic                    r_hold;
  logic                    r_en_ls, r_active, r_ls_ready, r_drain_to;
  logic                    w_ls_v, w_core_out_yumi;
  logic [ring_width_p-1:0] w_ls_data;
  logic [ring_width_p-1:0] r_mem [2];
  logic                    r_rd_ptr, r_wr_ptr;
  logic [1:0]              r_count, w_count_next;
  logic                    w_enq, w_deq;

  // Enable request synchronizer and FSM state register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= S_ISOLATED;
      r_cnt   <= '0;
      r_dcnt  <= '0;
    end else begin
      r_sync1 <= en_req_i;
      r_sync2 <= r_sync1;
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      r_dcnt  <= w_dcnt_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_dcnt_next  = r_dcnt;
    w_timeout    = 1'b0;
    case (r_state)
      S_ISOLATED: begin
        if (r_sync2) begin
          w_next_state = S_ARMING;
          w_cnt_next   = '0;
        end
      end
      S_ARMING: begin
        if (!r_sync2) begin
          w_next_state = S_ISOLATED;
        end else if (r_cnt == CW'(settle_cycles_p - 1)) begin
          w_next_state = S_ACTIVE;
        end else begin
          w_cnt_next = CW'(r_cnt + CW'(1));
        end
      end
      S_ACTIVE: begin
        if (!r_sync2) begin
          w_next_state = S_DRAINING;
          w_dcnt_next  = '0;
        end
      end
      S_DRAINING: begin
        // Re-enable wins; a consumed or absent packet ends the drain before the timeout does
        if (r_sync2) begin
          w_next_state = S_ACTIVE;
        end else if (!w_ls_v || ls_yumi_i) begin
          w_next_state = S_ISOLATED;
        end else if (r_dcnt == DW'(drain_timeout_p)) begin
          w_next_state = S_ISOLATED;
          w_timeout    = 1'b1;
        end else begin
          w_dcnt_next = DW'(r_dcnt + DW'(1));
        end
      end
      default: w_next_state = S_ISOLATED;
    endcase
  end

  // Node-to-FSB path is combinational; draining only keeps an already-presented packet up
  always_comb begin
    w_ls_v          = 1'b0;
    w_ls_data       = '0;
    w_core_out_yumi = 1'b0;
    case (r_state)
      S_ACTIVE: begin
        w_ls_v          = core_out_v_i;
        w_ls_data       = core_out_data_i;
        w_core_out_yumi = ls_yumi_i;
      end
      S_DRAINING: begin
        w_ls_v          = core_out_v_i & r_hold;
        w_ls_data       = w_ls_v ? core_out_data_i : '0;
        w_core_out_yumi = ls_yumi_i & w_ls_v;
      end
      default: ;
    endcase
  end

  assign w_enq = ls_v_i & r_ls_ready;
  assign w_deq = core_yumi_i & (r_count != 2'd0);
  assign w_count_next = 2'(r_count + 2'(w_enq) - 2'(w_deq));

  // Registered status outputs, hold flag and FIFO storage
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_en_ls    <= 1'b0;
      r_active   <= 1'b0;
      r_ls_ready <= 1'b0;
      r_drain_to <= 1'b0;
      r_hold     <= 1'b0;
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_en_ls    <= (w_next_state != S_ISOLATED);
      r_active   <= (w_next_state == S_ACTIVE);
      r_ls_ready <= (w_next_state == S_ACTIVE) && (w_count_next != 2'd2);
      r_drain_to <= w_timeout;
      r_hold     <= w_ls_v & ~ls_yumi_i;
      r_count    <= w_count_next;
      if (w_enq) begin
        r_mem[r_wr_ptr] <= ls_data_i;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_deq) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  assign en_ls_o         = r_en_ls;
  assign active_o        = r_active;
  assign drain_timeout_o = r_drain_to;
  assign ls_ready_o      = r_ls_ready;
  assign core_v_o        = (r_count != 2'd0);
  assign core_data_o     = r_mem[r_rd_ptr];
  assign ls_v_o          = w_ls_v;
  assign ls_data_o       = w_ls_data;
  assign core_out_yumi_o = w_core_out_yumi;

endmodule

// File: tb/tb_bsg_fsb_node_domain_ls_gate.sv
// Directed bench for bsg_fsb_node_domain_ls_gate: enable sequencing, FIFO
// backpressure, drain/timeout, aborts and asynchronous reset.
module tb_bsg_fsb_node_domain_ls_gate;

  localparam int unsigned RW     = 80;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned DTO    = 8;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          en_req_i;
  logic          en_ls_o, active_o, drain_timeout_o;
  logic          ls_v_i;
  logic [RW-1:0] ls_data_i;
  logic          ls_ready_o;
  logic          core_v_o;
  logic [RW-1:0] core_data_o;
  logic          core_yumi_i;
  logic          core_out_v_i;
  logic [RW-1:0] core_out_data_i;
  logic          core_out_yumi_o;
  logic          ls_v_o;
  logic [RW-1:0] ls_data_o;
  logic          ls_yumi_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  bsg_fsb_node_domain_ls_gate #(
    .ring_width_p(RW), .settle_cycles_p(SETTLE), .drain_timeout_p(DTO)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_req_i(en_req_i),
    .en_ls_o(en_ls_o), .active_o(active_o), .drain_timeout_o(drain_timeout_o),
    .ls_v_i(ls_v_i), .ls_data_i(ls_data_i), .ls_ready_o(ls_ready_o),
    .core_v_o(core_v_o), .core_data_o(core_data_o), .core_yumi_i(core_yumi_i),
    .core_out_v_i(core_out_v_i), .core_out_data_i(core_out_data_i),
    .core_out_yumi_o(core_out_yumi_o), .ls_v_o(ls_v_o), .ls_data_o(ls_data_o),
    .ls_yumi_i(ls_yumi_i)
  );

  typedef struct {
    logic en_ls;
    logic active;
    logic ready;
  } en_vec_t;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       yumi;
    logic       exp_core_v;
    logic [7:0] exp_data;
    logic       exp_ready;
  } fifo_vec_t;

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_active(input string nm);
    for (int i = 0; i < 20; i++) begin
      if (active_o) break;
      step();
    end
    chk(nm, RW'(active_o), RW'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en_ls"}, RW'(en_ls_o), '0);
    chk({tag, "_active"}, RW'(active_o), '0);
    chk({tag, "_drain_to"}, RW'(drain_timeout_o), '0);
    chk({tag, "_ls_ready"}, RW'(ls_ready_o), '0);
    chk({tag, "_core_v"}, RW'(core_v_o), '0);
    chk({tag, "_core_data"}, core_data_o, '0);
    chk({tag, "_core_out_yumi"}, RW'(core_out_yumi_o), '0);
    chk({tag, "_ls_v"}, RW'(ls_v_o), '0);
    chk({tag, "_ls_data"}, ls_data_o, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    en_vec_t   ev [8];
    fifo_vec_t fv [6];
    int        pulses;
    logic      seen;

    // Edge k after raising en_req_i: ARMING after edge 3, ACTIVE after edge 3+SETTLE
    ev[0] = '{0, 0, 0}; ev[1] = '{0, 0, 0}; ev[2] = '{1, 0, 0}; ev[3] = '{1, 0, 0};
    ev[4] = '{1, 0, 0}; ev[5] = '{1, 0, 0}; ev[6] = '{1, 1, 1}; ev[7] = '{1, 1, 1};
    // FSB pushes 1,2,3 against a stalled then draining core
    fv[0] = '{1, 8'd1, 0, 1, 8'd1, 1};
    fv[1] = '{1, 8'd2, 0, 1, 8'd1, 0};
    fv[2] = '{1, 8'd3, 0, 1, 8'd1, 0};
    fv[3] = '{1, 8'd3, 1, 1, 8'd2, 1};
    fv[4] = '{1, 8'd3, 1, 1, 8'd3, 1};
    fv[5] = '{0, 8'd0, 1, 0, 8'd0, 1};

    reset_i = 1'b0; en_req_i = 1'b0; ls_v_i = 1'b0; ls_data_i = '0;
    core_yumi_i = 1'b0; core_out_v_i = 1'b0; core_out_data_i = '0; ls_yumi_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_all_zero("reset");
    reset_i = 1'b1;

    en_req_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("enseq_en_ls_e%0d", k + 1), RW'(en_ls_o), RW'(ev[k].en_ls));
      chk($sformatf("enseq_active_e%0d", k + 1), RW'(active_o), RW'(ev[k].active));
      chk($sformatf("enseq_ready_e%0d", k + 1), RW'(ls_ready_o), RW'(ev[k].ready));
    end

    for (int i = 0; i < 6; i++) begin
      ls_v_i = fv[i].v; ls_data_i = RW'(fv[i].d); core_yumi_i = fv[i].yumi;
      step();
      chk($sformatf("fifo_core_v_r%0d", i), RW'(core_v_o), RW'(fv[i].exp_core_v));
      chk($sformatf("fifo_ready_r%0d", i), RW'(ls_ready_o), RW'(fv[i].exp_ready));
      if (fv[i].exp_core_v)
        chk($sformatf("fifo_data_r%0d", i), core_data_o, RW'(fv[i].exp_data));
    end
    ls_v_i = 1'b0; ls_data_i = '0; core_yumi_i = 1'b0;

    core_out_v_i = 1'b1; core_out_data_i = RW'(8'hAB); ls_yumi_i = 1'b1;
    #1;
    chk("pass_ls_v", RW'(ls_v_o), RW'(1));
    chk("pass_ls_data", ls_data_o, RW'(8'hAB));
    chk("pass_out_yumi", RW'(core_out_yumi_o), RW'(1));

    // Drain with a pending packet consumed on the 5th DRAINING cycle
    ls_yumi_i = 1'b0; core_out_data_i = RW'(8'h55); en_req_i = 1'b0;
    repeat (3) step();
    chk("drain_active", RW'(active_o), '0);
    chk("drain_en_ls", RW'(en_ls_o), RW'(1));
    chk("drain_ls_v", RW'(ls_v_o), RW'(1));
    chk("drain_ready", RW'(ls_ready_o), '0);
    repeat (4) step();
    chk("drain_c5_ls_v", RW'(ls_v_o), RW'(1));
    chk("drain_c5_ls_data", ls_data_o, RW'(8'h55));
    ls_yumi_i = 1'b1;
    #1;
    chk("drain_c5_out_yumi", RW'(core_out_yumi_o), RW'(1));
    step();
    chk("drain_exit_en_ls", RW'(en_ls_o), '0);
    chk("drain_exit_to", RW'(drain_timeout_o), '0);
    chk("drain_exit_ls_v", RW'(ls_v_o), '0);
    ls_yumi_i = 1'b0; core_out_v_i = 1'b0;

    // Drain timeout with the FSB never consuming
    en_req_i = 1'b1;
    wait_active("to_wait_active");
    core_out_v_i = 1'b1; en_req_i = 1'b0;
    pulses = 0;
    repeat (30) begin
      step();
      if (drain_timeout_o) pulses++;
    end
    chk("to_pulses", RW'(pulses), RW'(1));
    chk("to_en_ls", RW'(en_ls_o), '0);
    chk("to_ls_v", RW'(ls_v_o), '0);
    core_out_v_i = 1'b0;

    // Abort during ARMING
    en_req_i = 1'b1;
    repeat (3) step();
    chk("arm_abort_en_ls", RW'(en_ls_o), RW'(1));
    en_req_i = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      step();
      if (active_o) seen = 1'b1;
    end
    chk("arm_abort_never_active", RW'(seen), '0);
    chk("arm_abort_en_ls_off", RW'(en_ls_o), '0);

    // Re-enable during DRAINING
    en_req_i = 1'b1;
    wait_active("dabort_wait1");
    core_out_v_i = 1'b1; en_req_i = 1'b0;
    repeat (3) step();
    chk("dabort_in_drain", RW'(active_o), '0);
    chk("dabort_en_ls", RW'(en_ls_o), RW'(1));
    en_req_i = 1'b1;
    wait_active("dabort_wait2");
    chk("dabort_ready", RW'(ls_ready_o), RW'(1));
    core_out_v_i = 1'b0;

    // Asynchronous reset with a full FIFO and a packet on the output
    ls_v_i = 1'b1; ls_data_i = RW'(8'h11);
    step();
    ls_data_i = RW'(8'h22);
    step();
    ls_v_i = 1'b0;
    chk("rst_fifo_full_core_v", RW'(core_v_o), RW'(1));
    chk("rst_fifo_full_ready", RW'(ls_ready_o), '0);
    core_out_v_i = 1'b1; core_out_data_i = RW'(8'h77);
    #3;
    reset_i = 1'b0;
    #1;
    chk_all_zero("async_rst");
    en_req_i = 1'b0; core_out_v_i = 1'b0; core_out_data_i = '0;
    @(negedge clk_i);
    reset_i = 1'b1;
    step();
    chk("post_rst_core_v", RW'(core_v_o), '0);
    chk("post_rst_en_ls", RW'(en_ls_o), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
